// File: rtl/test_supervisor_pkg.sv
// ----------------------------------------------------------------------------
// test_supervisor_pkg
// Shared definitions for the test supervisor: the FSM state encoding and the
// two-bit status codes reported to the testbench top.
// ----------------------------------------------------------------------------
package test_supervisor_pkg;

    typedef enum logic [2:0] {
        RST_HOLD = 3'd0,
        RUN      = 3'd1,
        PASS     = 3'd2,
        FAIL     = 3'd3,
        TMO      = 3'd4
    } state_t;

    localparam logic [1:0] ST_RUNNING = 2'b00;
    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_FAIL    = 2'b10;
    localparam logic [1:0] ST_TMO     = 2'b11;

endpackage

// File: rtl/test_supervisor_if.sv
// ----------------------------------------------------------------------------
// test_supervisor_if
// Bundles the supervisor's control/verdict/report signals.
//   master : the supervisor side (drives sys_rst, cycle_count, done, status,
//            fail_cycle, end_cycle; receives start, sys_success, sys_fail)
//   slave  : the host / testbench side (the mirror image)
// ----------------------------------------------------------------------------
interface test_supervisor_if #(
    parameter int CNT_W = 32
);

    logic             start;
    logic             sys_rst;
    logic             sys_success;
    logic             sys_fail;
    logic             done;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] fail_cycle;
    logic [CNT_W-1:0] end_cycle;

    modport master (
        input  start, sys_success, sys_fail,
        output sys_rst, cycle_count, done, status, fail_cycle, end_cycle
    );

    modport slave (
        output start, sys_success, sys_fail,
        input  sys_rst, cycle_count, done, status, fail_cycle, end_cycle
    );

endinterface

// File: rtl/test_supervisor_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Registered up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock and asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable
//   q          : counter value
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // Saturating count with clear priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {W{1'b0}};
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + W'(1);
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/test_supervisor.sv
// ----------------------------------------------------------------------------
// test_supervisor
// Sequences a test host's reset, supplies the shared cycle counter, samples
// the host verdict flags, enforces a run timeout and latches a final status.
// A start pulse in a terminal state re-arms a fresh run.
//   sys_clk    : system clock
//   sys_rst_n  : asynchronous active-low reset
//   bus        : test_supervisor_if.master (start, sys_rst, cycle_count,
//                sys_success, sys_fail, done, status, fail_cycle, end_cycle)
// ----------------------------------------------------------------------------
module test_supervisor
    import test_supervisor_pkg::*;
#(
    parameter int RST_CYCLES = 8,
    parameter int TIMEOUT    = 1000,
    parameter int CNT_W      = 32
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    test_supervisor_if.master  bus
);

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam int RUN_W  = $clog2(TIMEOUT + 1);

    if ((RST_CYCLES < 1) || (TIMEOUT < 1)) begin : g_param_check
        $error("test_supervisor: RST_CYCLES and TIMEOUT must both be >= 1");
    end

    state_t             state_r;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [RUN_W-1:0]   run_cnt_r;
    logic               sys_rst_r;
    logic               done_r;
    logic [1:0]         status_r;
    logic [CNT_W-1:0]   fail_cycle_r;
    logic [CNT_W-1:0]   end_cycle_r;
    logic [CNT_W-1:0]   cycle_count_s;
    logic               cnt_clr_s;
    logic               cnt_en_s;
    logic               run_last_s;

    assign run_last_s = (run_cnt_r == RUN_W'(TIMEOUT - 1));

    // Cycle counter control: count through hold and run, but not on the edge
    // that enters a terminal state, so end_cycle equals the frozen count.
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        case (state_r)
            RST_HOLD: cnt_en_s = 1'b1;
            RUN:      cnt_en_s = !bus.sys_fail && !bus.sys_success && !run_last_s;
            PASS, FAIL, TMO: cnt_clr_s = bus.start;
            default:  cnt_clr_s = 1'b1;
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .q     (cycle_count_s)
    );

    // Run-sequencing FSM with registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r      <= RST_HOLD;
            hold_cnt_r   <= {HOLD_W{1'b0}};
            run_cnt_r    <= {RUN_W{1'b0}};
            sys_rst_r    <= 1'b1;
            done_r       <= 1'b0;
            status_r     <= ST_RUNNING;
            fail_cycle_r <= {CNT_W{1'b0}};
            end_cycle_r  <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                RST_HOLD: begin
                    if (hold_cnt_r == HOLD_W'(RST_CYCLES - 1)) begin
                        state_r    <= RUN;
                        sys_rst_r  <= 1'b0;
                        hold_cnt_r <= {HOLD_W{1'b0}};
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_W'(1);
                    end
                end
                RUN: begin
                    // Verdicts outrank the timeout; fail outranks success.
                    if (bus.sys_fail) begin
                        state_r      <= FAIL;
                        done_r       <= 1'b1;
                        status_r     <= ST_FAIL;
                        sys_rst_r    <= 1'b1;
                        fail_cycle_r <= cycle_count_s;
                        end_cycle_r  <= cycle_count_s;
                    end else if (bus.sys_success) begin
                        state_r     <= PASS;
                        done_r      <= 1'b1;
                        status_r    <= ST_PASS;
                        sys_rst_r   <= 1'b1;
                        end_cycle_r <= cycle_count_s;
                    end else if (run_last_s) begin
                        state_r     <= TMO;
                        done_r      <= 1'b1;
                        status_r    <= ST_TMO;
                        sys_rst_r   <= 1'b1;
                        end_cycle_r <= cycle_count_s;
                    end else begin
                        run_cnt_r <= (run_cnt_r == {RUN_W{1'b1}}) ? run_cnt_r
                                                                  : run_cnt_r + RUN_W'(1);
                    end
                end
                PASS, FAIL, TMO: begin
                    if (bus.start) begin
                        state_r      <= RST_HOLD;
                        hold_cnt_r   <= {HOLD_W{1'b0}};
                        run_cnt_r    <= {RUN_W{1'b0}};
                        sys_rst_r    <= 1'b1;
                        done_r       <= 1'b0;
                        status_r     <= ST_RUNNING;
                        fail_cycle_r <= {CNT_W{1'b0}};
                        end_cycle_r  <= {CNT_W{1'b0}};
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r      <= RST_HOLD;
                    hold_cnt_r   <= {HOLD_W{1'b0}};
                    run_cnt_r    <= {RUN_W{1'b0}};
                    sys_rst_r    <= 1'b1;
                    done_r       <= 1'b0;
                    status_r     <= ST_RUNNING;
                    fail_cycle_r <= {CNT_W{1'b0}};
                    end_cycle_r  <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign bus.sys_rst     = sys_rst_r;
    assign bus.done        = done_r;
    assign bus.status      = status_r;
    assign bus.cycle_count = cycle_count_s;
    assign bus.fail_cycle  = fail_cycle_r;
    assign bus.end_cycle   = end_cycle_r;

endmodule

// File: tb/tb_test_supervisor.sv
// ----------------------------------------------------------------------------
// tb_test_supervisor
// Two supervisors share the clock and reset:
//   a : RST_CYCLES=4, TIMEOUT=16, CNT_W=32 (directed scenarios)
//   b : RST_CYCLES=4, TIMEOUT=40, CNT_W=4  (counter saturation, timeout)
// A run-level model predicts every output each cycle; literal expectations
// pin the scenario outcomes.
// ----------------------------------------------------------------------------
module tb_test_supervisor;

    logic sys_clk;
    logic sys_rst_n;
    bit   cmp_en;
    int   n_tests;
    int   n_fail;

    test_supervisor_if #(.CNT_W(32)) if_a ();
    test_supervisor_if #(.CNT_W(4))  if_b ();

    test_supervisor #(.RST_CYCLES(4), .TIMEOUT(16), .CNT_W(32)) dut_a (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (if_a)
    );

    test_supervisor #(.RST_CYCLES(4), .TIMEOUT(40), .CNT_W(4)) dut_b (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (if_b)
    );

    // Clock generation.
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Run model: k = edges since the run was armed; the first r edges are the
    // hold window, edge index k-r inside the run is the run cycle number.
    typedef struct {
        int     k;
        bit     done;
        bit [1:0] status;
        longint cc;
        longint fc;
        longint ec;
    } m_t;

    m_t ma;
    m_t mb;

    function automatic m_t step(m_t m, bit st, bit suc, bit fl, int r, int t, longint maxc);
        m_t n;
        n = m;
        if (m.done) begin
            if (st) n = '{default: 0};
        end else if (m.k < r) begin
            n.k  = m.k + 1;
            n.cc = (m.cc < maxc) ? m.cc + 1 : maxc;
        end else if (fl) begin
            n.done = 1'b1; n.status = 2'b10; n.fc = m.cc; n.ec = m.cc;
        end else if (suc) begin
            n.done = 1'b1; n.status = 2'b01; n.ec = m.cc;
        end else if ((m.k - r) == (t - 1)) begin
            n.done = 1'b1; n.status = 2'b11; n.ec = m.cc;
        end else begin
            n.k  = m.k + 1;
            n.cc = (m.cc < maxc) ? m.cc + 1 : maxc;
        end
        return n;
    endfunction

    function automatic bit exp_rst(m_t m, int r);
        return m.done || (m.k < r);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model update on the same edges the DUTs sample.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ma <= '{default: 0};
            mb <= '{default: 0};
        end else begin
            ma <= step(ma, if_a.start, if_a.sys_success, if_a.sys_fail, 4, 16, 64'hFFFF_FFFF);
            mb <= step(mb, if_b.start, if_b.sys_success, if_b.sys_fail, 4, 40, 64'd15);
        end
    end

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge sys_clk) begin
        if (cmp_en) begin
            chk("a.sys_rst",     if_a.sys_rst,     exp_rst(ma, 4));
            chk("a.done",        if_a.done,        ma.done);
            chk("a.status",      if_a.status,      ma.status);
            chk("a.cycle_count", if_a.cycle_count, ma.cc);
            chk("a.fail_cycle",  if_a.fail_cycle,  ma.fc);
            chk("a.end_cycle",   if_a.end_cycle,   ma.ec);
            chk("b.sys_rst",     if_b.sys_rst,     exp_rst(mb, 4));
            chk("b.done",        if_b.done,        mb.done);
            chk("b.status",      if_b.status,      mb.status);
            chk("b.cycle_count", if_b.cycle_count, mb.cc);
            chk("b.fail_cycle",  if_b.fail_cycle,  mb.fc);
            chk("b.end_cycle",   if_b.end_cycle,   mb.ec);
        end
    end

    task automatic pulse_start();
        if_a.start = 1'b1;
        @(negedge sys_clk);
        if_a.start = 1'b0;
    endtask

    task automatic wait_cc(input longint v);
        for (int i = 0; i < 100 && if_a.cycle_count != v[31:0]; i++) @(negedge sys_clk);
        chk("wait_cc", if_a.cycle_count, v);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && if_a.done !== 1'b1; i++) @(negedge sys_clk);
        chk("wait_done", if_a.done, 1);
    endtask

    // Directed scenarios.
    initial begin
        n_tests = 0;
        n_fail  = 0;
        cmp_en  = 1'b0;
        if_a.start = 1'b0; if_a.sys_success = 1'b0; if_a.sys_fail = 1'b0;
        if_b.start = 1'b0; if_b.sys_success = 1'b0; if_b.sys_fail = 1'b0;
        sys_rst_n = 1'b1;
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        cmp_en = 1'b1;

        chk("rst.sys_rst", if_a.sys_rst, 1);
        chk("rst.done", if_a.done, 0);
        chk("rst.status", if_a.status, 0);
        chk("rst.cycle_count", if_a.cycle_count, 0);
        chk("rst.end_cycle", if_a.end_cycle, 0);

        // Reset release: four hold edges, counting 0..4.
        sys_rst_n = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            chk("t1.cycle_count", if_a.cycle_count, i);
            chk("t1.sys_rst", if_a.sys_rst, (i < 4) ? 1 : 0);
            if (i < 4) @(negedge sys_clk);
        end

        // start during RUN is ignored; success on RUN cycle 3.
        pulse_start();
        chk("t5.run_start_ignored", if_a.sys_rst, 0);
        wait_cc(7);
        if_a.sys_success = 1'b1;
        @(negedge sys_clk);
        if_a.sys_success = 1'b0;
        chk("t2.done", if_a.done, 1);
        chk("t2.status", if_a.status, 1);
        chk("t2.sys_rst", if_a.sys_rst, 1);
        chk("t2.end_cycle", if_a.end_cycle, 7);
        @(negedge sys_clk);
        chk("t2.frozen", if_a.cycle_count, 7);

        // start in PASS clears everything.
        pulse_start();
        chk("t5.done", if_a.done, 0);
        chk("t5.status", if_a.status, 0);
        chk("t5.cycle_count", if_a.cycle_count, 0);
        chk("t5.end_cycle", if_a.end_cycle, 0);
        chk("t5.sys_rst", if_a.sys_rst, 1);

        // Simultaneous fail and success on RUN cycle 2.
        wait_cc(6);
        if_a.sys_fail = 1'b1; if_a.sys_success = 1'b1;
        @(negedge sys_clk);
        if_a.sys_fail = 1'b0;
        chk("t3.status", if_a.status, 2);
        chk("t3.fail_cycle", if_a.fail_cycle, 6);
        chk("t3.end_cycle", if_a.end_cycle, 6);
        repeat (2) @(negedge sys_clk);
        chk("t3.late_success", if_a.status, 2);
        if_a.sys_success = 1'b0;

        // Pure timeout.
        pulse_start();
        wait_done();
        chk("t4.status", if_a.status, 3);
        chk("t4.end_cycle", if_a.end_cycle, 19);

        // Success on RUN cycle 15 beats the timeout.
        pulse_start();
        wait_cc(19);
        if_a.sys_success = 1'b1;
        @(negedge sys_clk);
        if_a.sys_success = 1'b0;
        chk("t4.succ_status", if_a.status, 1);
        chk("t4.succ_end", if_a.end_cycle, 19);

        // Fail on RUN cycle 15 beats the timeout.
        pulse_start();
        wait_cc(19);
        if_a.sys_fail = 1'b1;
        @(negedge sys_clk);
        if_a.sys_fail = 1'b0;
        chk("t4.fail_status", if_a.status, 2);
        chk("t4.fail_cycle", if_a.fail_cycle, 19);

        // Narrow counter saturates at 15 and the run times out.
        chk("t6.b_done", if_b.done, 1);
        chk("t6.b_status", if_b.status, 3);
        chk("t6.b_cycle_count", if_b.cycle_count, 15);
        chk("t6.b_end_cycle", if_b.end_cycle, 15);

        // Asynchronous reset mid-run.
        pulse_start();
        wait_cc(10);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t6.rst_sys_rst", if_a.sys_rst, 1);
        chk("t6.rst_cycle_count", if_a.cycle_count, 0);
        chk("t6.rst_done", if_a.done, 0);
        chk("t6.rst_status", if_a.status, 0);
        chk("t6.rst_b_cycle_count", if_b.cycle_count, 0);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        wait_done();
        chk("t6.after_status", if_a.status, 3);
        chk("t6.after_end", if_a.end_cycle, 19);
        @(negedge sys_clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
